// File: rtl/qos_wrr_arbiter.sv
// N-channel QoS arbiter: fixed priority, round robin, weighted round robin or
// table-driven slot scheduling, selected per cycle by sel. Grant is registered.
module qos_wrr_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned WEIGHT_W  = 2,
    parameter int unsigned TBL_SLOTS = 16,
    parameter int unsigned SLOT_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enb,
    input  logic [1:0]                   sel,
    input  logic [N_CH-1:0]              req,
    input  logic [N_CH*WEIGHT_W-1:0]     weight,
    input  logic [TBL_SLOTS*IDX_W-1:0]   TABLE,
    output logic [N_CH-1:0]              grant,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         grant_valid
);

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_RR    = 2'd1,
        MODE_WRR   = 2'd2,
        MODE_TABLE = 2'd3
    } mode_t;

    mode_t                mode;
    mode_t                sel_q;
    logic [IDX_W-1:0]     rr_ptr;
    logic [SLOT_W-1:0]    tbl_ptr;
    logic [WEIGHT_W-1:0]  credit;

    logic [(1<<IDX_W)-1:0] req_pad;
    logic [IDX_W-1:0]      tbl [TBL_SLOTS];
    logic [WEIGHT_W-1:0]   wts [N_CH];

    logic [IDX_W-1:0]     fp_win;
    logic [IDX_W-1:0]     rr_win, rr_c, rr_next;
    logic                 rr_hit;
    logic [IDX_W-1:0]     tb_ch;
    logic [SLOT_W-1:0]    tb_slot, tb_s, tb_next;
    logic                 tb_found;
    logic                 burst_hold;

    assign mode = mode_t'(sel);

    for (genvar g = 0; g < TBL_SLOTS; g++) begin : g_tbl
        assign tbl[g] = TABLE[g*IDX_W +: IDX_W];
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_wts
        assign wts[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    // Padded to a power of two so any encoded channel/table entry indexes safely.
    always_comb begin
        req_pad = '0;
        req_pad[N_CH-1:0] = req;
    end

    always_comb begin
        fp_win = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (req_pad[IDX_W'(i-1)]) fp_win = IDX_W'(i-1);
        end
    end

    always_comb begin
        rr_win = '0;
        rr_c   = '0;
        rr_hit = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rr_c = IDX_W'((32'(rr_ptr) + i) % N_CH);
            if (!rr_hit && req_pad[rr_c]) begin
                rr_hit = 1'b1;
                rr_win = rr_c;
            end
        end
        rr_next = IDX_W'((32'(rr_win) + 1) % N_CH);
    end

    // Whole table is scanned combinationally; out-of-range entries never match.
    always_comb begin
        tb_ch    = '0;
        tb_slot  = '0;
        tb_s     = '0;
        tb_found = 1'b0;
        for (int unsigned i = 0; i < TBL_SLOTS; i++) begin
            tb_s = SLOT_W'((32'(tbl_ptr) + i) % TBL_SLOTS);
            if (!tb_found && (32'(tbl[tb_s]) < N_CH) && req_pad[tbl[tb_s]]) begin
                tb_found = 1'b1;
                tb_slot  = tb_s;
                tb_ch    = tbl[tb_s];
            end
        end
        tb_next = SLOT_W'((32'(tb_slot) + 1) % TBL_SLOTS);
    end

    assign burst_hold = grant_valid && req_pad[grant_idx] && (credit != '0) && (sel_q == MODE_WRR);

    function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= '0;
            credit      <= '0;
            tbl_ptr     <= '0;
            sel_q       <= MODE_FIXED;
        end else begin
            sel_q <= mode;
            if (!enb || (req == '0)) begin
                grant       <= '0;
                grant_valid <= 1'b0;
                credit      <= '0;
            end else begin
                unique case (mode)
                    MODE_FIXED: begin
                        grant       <= onehot(fp_win);
                        grant_idx   <= fp_win;
                        grant_valid <= 1'b1;
                        credit      <= '0;
                    end
                    MODE_RR: begin
                        grant       <= onehot(rr_win);
                        grant_idx   <= rr_win;
                        grant_valid <= 1'b1;
                        rr_ptr      <= rr_next;
                        credit      <= '0;
                    end
                    MODE_WRR: begin
                        if (burst_hold) begin
                            credit <= credit - 1'b1;
                        end else begin
                            grant       <= onehot(rr_win);
                            grant_idx   <= rr_win;
                            grant_valid <= 1'b1;
                            rr_ptr      <= rr_next;
                            credit      <= wts[rr_win];
                        end
                    end
                    MODE_TABLE: begin
                        credit <= '0;
                        if (tb_found) begin
                            grant       <= onehot(tb_ch);
                            grant_idx   <= tb_ch;
                            grant_valid <= 1'b1;
                            tbl_ptr     <= tb_next;
                        end else begin
                            grant       <= '0;
                            grant_valid <= 1'b0;
                        end
                    end
                    default: begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        credit      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Bench for qos_wrr_arbiter: behavioural scheduler model checked every cycle,
// plus directed sequences with literal expected grant orders.
module tb_qos_wrr_arbiter;

    logic        clk;
    logic        reset;
    logic        enb;
    logic [1:0]  sel;
    logic [3:0]  req;
    logic [7:0]  weight;
    logic [31:0] TABLE;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        grant_valid;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    qos_wrr_arbiter #(
        .N_CH(4), .IDX_W(2), .WEIGHT_W(2), .TBL_SLOTS(16), .SLOT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .enb(enb), .sel(sel), .req(req),
        .weight(weight), .TABLE(TABLE), .grant(grant),
        .grant_idx(grant_idx), .grant_valid(grant_valid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Scheduler model: per-edge decision using the policy rules directly.
    int m_rr, m_tp, m_left, m_idx, m_prevsel;
    bit m_valid;
    int w, ns, c, s;
    bit hold;

    always @(posedge clk) begin
        if (reset) begin
            m_rr = 0; m_tp = 0; m_left = 0; m_idx = 0; m_valid = 0; m_prevsel = 0;
        end else begin
            w = -1;
            ns = 0;
            hold = enb && (req != 0) && sel == 2 && m_prevsel == 2 && m_valid
                   && req[m_idx] && m_left > 0;
            if (!enb || req == 0) begin
                m_valid = 0;
                m_left = 0;
            end else if (hold) begin
                m_left = m_left - 1;
            end else begin
                case (sel)
                    2'd0: for (int i = 0; i < 4; i++) if (w < 0 && req[i]) w = i;
                    2'd1, 2'd2: begin
                        for (int k = 0; k < 4; k++) begin
                            c = (m_rr + k) % 4;
                            if (w < 0 && req[c]) w = c;
                        end
                        m_rr = (w + 1) % 4;
                    end
                    default: begin
                        for (int k = 0; k < 16; k++) begin
                            s = (m_tp + k) % 16;
                            c = int'(TABLE[s*2 +: 2]);
                            if (w < 0 && req[c]) begin w = c; ns = s; end
                        end
                        if (w >= 0) m_tp = (ns + 1) % 16;
                    end
                endcase
                m_left = (sel == 2 && w >= 0) ? int'(weight[w*2 +: 2]) : 0;
                if (w >= 0) begin m_valid = 1; m_idx = w; end
                else m_valid = 0;
            end
            m_prevsel = int'(sel);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("grant_valid", grant_valid, m_valid);
            check("grant_idx", grant_idx, m_idx);
            check("grant", grant, m_valid ? (4'b0001 << m_idx) : 4'b0000);
            check("valid_eq_or_grant", grant_valid, |grant);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idx(input string nm, input int idx);
        check({nm, "_valid"}, grant_valid, 1);
        check({nm, "_idx"}, grant_idx, idx);
    endtask

    int seq3a [5]  = '{0, 1, 2, 3, 0};
    int seq3b [4]  = '{2, 0, 2, 0};
    int seq4  [13] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 0, 0, 0};
    int seq4b [5]  = '{1, 1, 2, 3, 3};
    int seq5  [17] = '{0, 1, 2, 3, 3, 2, 1, 2, 3, 1, 2, 1, 0, 3, 2, 2, 0};

    initial begin
        reset = 1; enb = 1; sel = 2'd3; req = 4'hF; weight = 8'h5A; TABLE = 32'h1234_ABCD;
        step();
        started = 1;
        step();
        check("reset_grant", grant, 0);
        check("reset_valid", grant_valid, 0);
        check("reset_idx", grant_idx, 0);
        reset = 0; req = 4'b0000; sel = 2'd0;
        repeat (3) step();
        check("idle_valid", grant_valid, 0);

        // fixed priority
        req = 4'b1010;
        repeat (3) begin step(); check("fp_1010", grant, 4'b0010); end
        req = 4'b1000;
        step(); check("fp_1000", grant, 4'b1000);

        // round robin
        sel = 2'd1; req = 4'b1111;
        foreach (seq3a[i]) begin step(); expect_idx("rr_1111", seq3a[i]); end
        req = 4'b0101;
        foreach (seq3b[i]) begin step(); expect_idx("rr_0101", seq3b[i]); end
        req = 4'b1000;
        step(); expect_idx("rr_park", 3);

        // weighted round robin: ch3..ch0 weights 3,0,1,2
        sel = 2'd2; req = 4'b1111; weight = {2'd3, 2'd0, 2'd1, 2'd2};
        foreach (seq4[i]) begin step(); expect_idx("wrr_seq", seq4[i]); end
        foreach (seq4b[i]) begin step(); expect_idx("wrr_seq2", seq4b[i]); end
        req = 4'b0111;
        step(); expect_idx("wrr_drop", 0);
        enb = 0;
        step();
        check("enb_off_valid", grant_valid, 0);
        check("enb_off_grant", grant, 0);
        check("enb_off_idx", grant_idx, 0);
        enb = 1;
        step(); expect_idx("wrr_resume", 1);

        // switch to table mid-burst
        TABLE = 32'b1011_0001_1001_1110_0110_1111_1001_0010;
        sel = 2'd3; req = 4'b1111;
        step(); expect_idx("tbl_switch", 2);
        foreach (seq5[i]) begin step(); expect_idx("tbl_seq", seq5[i]); end
        req = 4'b0001;
        repeat (3) begin step(); expect_idx("tbl_ch0", 0); end
        req = 4'b1111;
        step(); expect_idx("tbl_s14", 3);
        step(); expect_idx("tbl_s15", 2);
        step(); expect_idx("tbl_s0", 2);
        reset = 1;
        step();
        check("tbl_reset_valid", grant_valid, 0);
        reset = 0;
        step(); expect_idx("tbl_restart0", 2);
        step(); expect_idx("tbl_restart1", 0);
        step(); expect_idx("tbl_restart2", 1);

        // mixed traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 60) == 0);
            enb    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            req    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) weight = 8'($urandom);
            if ($urandom_range(0, 20) == 0) TABLE = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
